// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath: control word bit positions
// and operating modes.
package alu_pkg;

    localparam int NCTRL = 13;

    localparam int C_LD_ADDSUB = 0;
    localparam int C_LD_MUL    = 1;
    localparam int C_LD_DIV    = 2;
    localparam int C_PREP      = 3;
    localparam int C_ARITH     = 4;
    localparam int C_SUB       = 5;
    localparam int C_DIV_QBIT  = 6;
    localparam int C_MUL_SHIFT = 7;
    localparam int C_DIV_STEP  = 8;
    localparam int C_MUL_STEP  = 9;
    localparam int C_DIV_FIX   = 10;
    localparam int C_OUT_LO    = 11;
    localparam int C_OUT_HI    = 12;

    typedef enum logic [1:0] {
        MODE_ADDSUB = 2'd0,
        MODE_MUL    = 2'd1,
        MODE_DIV    = 2'd2
    } mode_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational (W+1)-bit adder/subtractor; ovf flags signed overflow
// of the low W-bit operation.
module alu_addsub #(
    parameter int W = 8
) (
    input  logic [W:0] a,
    input  logic [W:0] b,
    input  logic       sub,
    output logic [W:0] sum,
    output logic       ovf
);

    logic [W:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign sum   = a + b_eff + {{W{1'b0}}, sub};
    assign ovf   = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);

endmodule

// File: rtl/alu_datapath.sv
// A/M/Q register datapath for add/sub, Booth multiply and non-restoring
// divide, sequenced by a one-hot control word.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [12:0]      c,
    input  logic [WIDTH-1:0] op_x,
    input  logic [WIDTH-1:0] op_y,
    output logic             q_0,
    output logic             q_min1,
    output logic             sign,
    output logic             cnt7,
    output logic [WIDTH-1:0] outbus,
    output logic             out_valid,
    output logic             ovf,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH:0]    a;
    logic [WIDTH:0]    m;
    logic [WIDTH-1:0]  q;
    logic [CNT_W-1:0]  cnt;
    mode_t             mode;
    logic [NCTRL-1:0]  sel;
    logic [WIDTH:0]    sum;
    logic              sum_ovf;
    logic              sub_en;

    // Isolate the lowest set control bit so a malformed word still decodes one-hot.
    assign sel    = c & (~c + 13'd1);
    assign sub_en = sel[C_ARITH] & c[C_SUB];

    alu_addsub #(
        .W(WIDTH)
    ) u_addsub (
        .a  (a),
        .b  (m),
        .sub(sub_en),
        .sum(sum),
        .ovf(sum_ovf)
    );

    assign q_0  = q[0];
    assign sign = a[WIDTH];
    assign cnt7 = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a           <= '0;
            m           <= '0;
            q           <= '0;
            q_min1      <= 1'b0;
            cnt         <= '0;
            mode        <= MODE_ADDSUB;
            outbus      <= '0;
            out_valid   <= 1'b0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (1'b1)
                sel[C_LD_ADDSUB]: begin
                    a           <= {op_x[WIDTH-1], op_x};
                    m           <= {op_y[WIDTH-1], op_y};
                    q           <= '0;
                    q_min1      <= 1'b0;
                    cnt         <= '0;
                    mode        <= MODE_ADDSUB;
                    ovf         <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                sel[C_LD_MUL]: begin
                    a           <= '0;
                    m           <= {op_y[WIDTH-1], op_y};
                    q           <= op_x;
                    q_min1      <= 1'b0;
                    cnt         <= '0;
                    mode        <= MODE_MUL;
                    ovf         <= 1'b0;
                    div_by_zero <= 1'b0;
                end
                sel[C_LD_DIV]: begin
                    a           <= '0;
                    m           <= {1'b0, op_y};
                    q           <= op_x;
                    q_min1      <= 1'b0;
                    cnt         <= '0;
                    mode        <= MODE_DIV;
                    ovf         <= 1'b0;
                    div_by_zero <= (op_y == '0);
                end
                sel[C_PREP]: begin
                    if (mode == MODE_DIV) {a, q} <= {a[WIDTH-1:0], q, 1'b0};
                end
                sel[C_ARITH]: begin
                    a <= sum;
                    if (mode == MODE_ADDSUB) ovf <= ovf | sum_ovf;
                end
                sel[C_SUB]: begin
                end
                sel[C_DIV_QBIT]: q[0] <= ~a[WIDTH];
                sel[C_MUL_SHIFT]: {a, q, q_min1} <= {a[WIDTH], a, q};
                sel[C_DIV_STEP]: begin
                    if (cnt != CNT_LAST) begin
                        {a, q} <= {a[WIDTH-1:0], q, 1'b0};
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                sel[C_MUL_STEP]: begin
                    if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
                end
                sel[C_DIV_FIX]: a <= sum;
                sel[C_OUT_LO]: begin
                    outbus    <= (mode == MODE_ADDSUB) ? a[WIDTH-1:0] : q;
                    out_valid <= 1'b1;
                end
                sel[C_OUT_HI]: begin
                    outbus    <= a[WIDTH-1:0];
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_datapath.sv
// Scoreboard bench for alu_datapath: a sequencing driver issues control
// words, an independent monitor checks every output beat.
module tb_alu_datapath;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] c;
    logic [7:0]  op_x;
    logic [7:0]  op_y;
    logic        q_0, q_min1, sign, cnt7;
    logic [7:0]  outbus;
    logic        out_valid, ovf, div_by_zero;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    alu_datapath #(.WIDTH(8), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .c          (c),
        .op_x       (op_x),
        .op_y       (op_y),
        .q_0        (q_0),
        .q_min1     (q_min1),
        .sign       (sign),
        .cnt7       (cnt7),
        .outbus     (outbus),
        .out_valid  (out_valid),
        .ovf        (ovf),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobed beat must match the oldest expected result.
    always @(negedge clk) begin
        if (out_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %0h expected none", outbus);
            end else begin
                chk("beat", {24'd0, outbus}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    function automatic logic [12:0] bitc(input int i);
        return 13'd1 << i;
    endfunction

    task automatic apply(input logic [12:0] cw);
        @(negedge clk);
        c = cw;
        @(posedge clk);
        #1;
        c = '0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic do_addsub(input logic [7:0] x, input logic [7:0] y,
                             input bit sub);
        int r;
        op_x = x;
        op_y = y;
        apply(bitc(C_LD_ADDSUB));
        apply(bitc(C_ARITH) | (sub ? bitc(C_SUB) : 13'd0));
        r = sub ? int'($signed(x)) - int'($signed(y))
                : int'($signed(x)) + int'($signed(y));
        chk("ovf", {31'd0, ovf}, {31'd0, (r > 127 || r < -128)});
        exp_q.push_back(8'(r));
        apply(bitc(C_OUT_LO));
        chk("ovf_hold", {31'd0, ovf}, {31'd0, (r > 127 || r < -128)});
        drain();
    endtask

    task automatic do_mul(input logic [7:0] x, input logic [7:0] y);
        int shifts;
        logic [31:0] p;
        op_x = x;
        op_y = y;
        apply(bitc(C_LD_MUL));
        shifts = 0;
        for (int i = 0; i < 20; i++) begin
            if (q_0 && !q_min1) apply(bitc(C_ARITH) | bitc(C_SUB));
            else if (!q_0 && q_min1) apply(bitc(C_ARITH));
            apply(bitc(C_MUL_SHIFT));
            shifts++;
            if (cnt7) break;
            apply(bitc(C_MUL_STEP));
        end
        chk("mul_shifts", shifts, 8);
        p = int'($signed(x)) * int'($signed(y));
        exp_q.push_back(p[7:0]);
        exp_q.push_back(p[15:8]);
        apply(bitc(C_OUT_LO));
        apply(bitc(C_OUT_HI));
        drain();
    endtask

    task automatic do_div(input logic [7:0] x, input logic [7:0] y);
        int n;
        bit sub;
        op_x = x;
        op_y = y;
        apply(bitc(C_LD_DIV));
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, (y == 8'd0)});
        apply(bitc(C_PREP));
        sub = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            apply(bitc(C_ARITH) | (sub ? bitc(C_SUB) : 13'd0));
            apply(bitc(C_DIV_QBIT));
            n++;
            sub = !sign;
            if (cnt7) break;
            apply(bitc(C_DIV_STEP));
        end
        if (sign) apply(bitc(C_DIV_FIX));
        chk("div_iters", n, 8);
        if (y == 8'd0) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(x);
        end else begin
            exp_q.push_back(x / y);
            exp_q.push_back(x % y);
        end
        apply(bitc(C_OUT_LO));
        apply(bitc(C_OUT_HI));
        chk("dbz_hold", {31'd0, div_by_zero}, {31'd0, (y == 8'd0)});
        drain();
    endtask

    task automatic mul_abort(input logic [7:0] x, input logic [7:0] y);
        op_x = x;
        op_y = y;
        apply(bitc(C_LD_MUL));
        for (int i = 0; i < 3; i++) begin
            if (q_0 && !q_min1) apply(bitc(C_ARITH) | bitc(C_SUB));
            else if (!q_0 && q_min1) apply(bitc(C_ARITH));
            apply(bitc(C_MUL_SHIFT));
            apply(bitc(C_MUL_STEP));
        end
        #2;
        rst = 1'b1;
        #1;
        chk("abort_state",
            {17'd0, q_0, q_min1, sign, cnt7, out_valid, ovf, div_by_zero, outbus},
            32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_beat", {31'd0, out_valid}, 32'd0);
        chk("abort_queue", exp_q.size(), 0);
    endtask

    initial begin
        rst  = 1'b1;
        c    = '0;
        op_x = '0;
        op_y = '0;
        #12;
        chk("reset_state",
            {17'd0, q_0, q_min1, sign, cnt7, out_valid, ovf, div_by_zero, outbus},
            32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_addsub(8'd25, 8'd17, 1'b0);
        do_addsub(8'd100, 8'd100, 1'b0);
        do_addsub(8'd5, 8'd9, 1'b1);
        do_addsub(8'h80, 8'h80, 1'b1);
        do_addsub(8'h80, 8'h01, 1'b1);
        do_mul(8'hFD, 8'd7);
        do_mul(8'h80, 8'h80);
        do_div(8'd100, 8'd7);
        do_div(8'd7, 8'd9);
        do_div(8'd7, 8'd0);
        do_div(8'd255, 8'd200);

        // Two load bits at once: the lower index (add/sub) must win.
        op_x = 8'd25;
        op_y = 8'd17;
        apply(bitc(C_LD_ADDSUB) | bitc(C_LD_MUL));
        apply(bitc(C_ARITH));
        exp_q.push_back(8'h2A);
        apply(bitc(C_OUT_LO));
        drain();

        mul_abort(8'hFD, 8'd7);
        do_addsub(8'd1, 8'd1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            do_addsub(8'($urandom), 8'($urandom), 1'($urandom));
            do_mul(8'($urandom), 8'($urandom));
            do_div(8'($urandom), 8'($urandom_range(0, 255)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
